gray_ptr_sync: RTL
==================

# gray_ptr_sync

Parametrised multi-stage synchronizer for Gray-coded FIFO pointers. It moves a pointer from the opposite clock domain into the local `clk` domain through a `STAGES`-deep flop chain. It also provides:
- the synchronized Gray word;
- its registered binary decode;
- a one-cycle change strobe;
- a sticky multi-bit-transition error flag, which detects pointers that violate the Gray one-bit-step rule.

It replaces the fixed two-flop word synchronizer in the async FIFO read/write pointer crossings.

## Interface
Parameters:
- `WORD_SIZE`, 4, pointer width in bits (≥1)
- `STAGES`, 2, synchronizer depth (≥2; values <2 are a elaboration error)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  local-domain clock
- `rst`  in  1  synchronous, active-high reset
- `inWord`  in  WORD_SIZE  Gray pointer from the foreign domain (asynchronous to `clk`)
- `errClear`  in  1  clears `multiBitErr`
- `outWord`  out  WORD_SIZE  synchronized Gray pointer
- `outBin`  out  WORD_SIZE  binary decode of `outWord`, registered
- `changed`  out  1  one-cycle pulse, aligned with `outBin`, when the synchronized pointer changed
- `multiBitErr`  out  1  sticky; a synchronized step changed more than one bit

## Operation
- **Chain:** `stage[0] <= inWord`, `stage[i] <= stage[i-1]`; `outWord` is `stage[STAGES-1]`. No logic between chain flops.
- **History:** `prevWord <= outWord` every cycle.
- **Decode:** every cycle `outBin <= gray2bin(outWord)`, where `bin[MSB] = g[MSB]` and `bin[i] = bin[i+1] ^ g[i]`.
- **Change strobe:** `changed <= (outWord != prevWord)`.
- **Error:** `multiBitErr` sets when `popcount(outWord ^ prevWord) > 1`.
  - Stays set until `errClear` is sampled high.
  - If set and clear occur in the same cycle, set wins.
- **Wrap-around:** `outBin` is a wrap of the Gray code at the MSB (e.g. 4-bit Gray 1000 → 0000). This is a one-bit step: no error, `changed`=1, `outBin` 15 → 0.
- **Reset:** when `rst`=1 at an edge, every chain stage, `prevWord`, `outWord`, `outBin`, `changed` and `multiBitErr` go to 0. Reset has priority over all other updates.
  - Reset mid-transfer discards in-flight values.
  - The first post-reset cycle never raises `changed` or the error, because `outWord` and `prevWord` are both 0.
- `errClear` during reset has no extra effect.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Value sampled into `stage[0]` at edge k:
  - appears on `outWord` after edge k+STAGES-1;
  - appears on `outBin`, `changed` and `multiBitErr` after edge k+STAGES.
- Total input-to-decode latency is `STAGES`+1 edges after first sample.
- `changed` is high for exactly one cycle per distinct synchronized value. Back-to-back steps give back-to-back pulses.
- `errClear` takes effect at the next edge; `multiBitErr` reads 0 the following cycle unless a new violation occurs in the same cycle.

## Structure
- Package `sync_pkg`:
  - function `gray2bin` (width-generic via `WORD_SIZE` argument);
  - function `popcount`;
  - constant `SYNC_MIN_STAGES` = 2, used in the parameter check.
- Sub-module `sync_chain`:
  - parameters `WIDTH` and `STAGES`; ports `clk`, `rst`, `d`, `q`;
  - pure flop chain with synchronous reset to 0;
  - reused for single-bit flag crossings elsewhere in the FIFO.
- Top level instantiates `sync_chain` and adds the `prevWord`, decode, strobe and error registers.
- Chain flops carry the team's synchronizer attribute so timing constraints find them.

## Test plan
(Defaults `WORD_SIZE`=4, `STAGES`=2 unless stated.)
- **Reset:** hold `rst` 3 cycles with `inWord`=1011 → every output is 0, including `outWord`, `outBin`, `changed` and `multiBitErr`. With `rst` still high, no output changes for the whole reset period.
- **Latency:** release reset, apply `inWord`=0001 before edge k → `outWord`=0001 after edge k+1; `outBin`=0001 and `changed`=1 after edge k+2; `changed`=0 after edge k+3.
- **Full count:** drive the Gray count 0..15 and wrap to 0, one step per 2 cycles → `outBin` tracks 0..15 then 0, with 16 `changed` pulses and `multiBitErr` never set.
- **Multi-bit jump:** 0000 → 0011 → `multiBitErr`=1 after edge k+2 and stays set for 10 cycles. Pulse `errClear` → 0 next cycle. Then apply `errClear` in the same cycle as a second violation (0011 → 0101) → flag remains 1.
- **Reset mid-flight:** assert `rst` one cycle after `inWord` steps 0000 → 0001 → the value never reaches `outWord`, all outputs are 0, and no `changed` pulse occurs after release.
- **Deep chain:** `STAGES`=3, `WORD_SIZE`=6, step to Gray 100000 → `outWord` after edge k+2; `outBin`=111111 and `changed`=1 after edge k+3.

Source files
------------

// File: rtl/sync_pkg.sv
// sync_pkg
// Shared helpers for the clock-domain-crossing pointer synchronizers.
//   SYNC_MIN_STAGES : smallest legal synchronizer depth
//   SYNC_MAX_WIDTH  : widest pointer the helper functions handle
//   gray2bin        : Gray-to-binary decode of the low 'width' bits
//   popcount        : number of set bits in a word
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_WIDTH  = 32;

  // Binary bit i is the XOR of every Gray bit from the MSB down to i.
  // Masking first keeps bits above 'width' from leaking into the result.
  function automatic logic [SYNC_MAX_WIDTH-1:0] gray2bin(
    input logic [SYNC_MAX_WIDTH-1:0] g,
    input int unsigned               width
  );
    logic [SYNC_MAX_WIDTH-1:0] masked;
    logic [SYNC_MAX_WIDTH-1:0] bin;
    masked = g;
    bin    = '0;
    for (int i = 0; i < SYNC_MAX_WIDTH; i++) begin
      if (i >= int'(width)) masked[i] = 1'b0;
    end
    for (int i = 0; i < SYNC_MAX_WIDTH; i++) begin
      bin[i] = ^(masked >> i);
    end
    return bin;
  endfunction

  function automatic int unsigned popcount(input logic [SYNC_MAX_WIDTH-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < SYNC_MAX_WIDTH; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain
// Plain flop chain for moving a signal into the 'clk' domain. Carries no
// logic between stages so every flop gets a full cycle to settle.
//   clk : local-domain clock
//   rst : synchronous, active-high reset (clears every stage)
//   d   : asynchronous input word
//   q   : output of the last stage
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Attribute lets the timing constraints locate the synchronizer flops.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

  // Shift the foreign-domain word one stage per clock; reset flushes
  // anything still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
// Brings a Gray-coded FIFO pointer from the opposite clock domain into
// 'clk', then decodes it and watches for illegal multi-bit steps.
//   clk         : local-domain clock
//   rst         : synchronous, active-high reset
//   inWord      : Gray pointer from the foreign domain
//   errClear    : clears the sticky multi-bit error
//   outWord     : synchronized Gray pointer
//   outBin      : registered binary decode of outWord
//   changed     : one-cycle pulse, aligned with outBin, on a new value
//   multiBitErr : sticky flag, a synchronized step flipped >1 bit
module gray_ptr_sync
  import sync_pkg::*;
#(
  parameter int WORD_SIZE = 4,
  parameter int STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inWord,
  input  logic                 errClear,
  output logic [WORD_SIZE-1:0] outWord,
  output logic [WORD_SIZE-1:0] outBin,
  output logic                 changed,
  output logic                 multiBitErr
);

  if (STAGES < SYNC_MIN_STAGES) begin : gStageCheck
    $error("gray_ptr_sync: STAGES must be at least SYNC_MIN_STAGES");
  end
  if (WORD_SIZE < 1 || WORD_SIZE > SYNC_MAX_WIDTH) begin : gWidthCheck
    $error("gray_ptr_sync: WORD_SIZE out of supported range");
  end

  logic [WORD_SIZE-1:0]      prevWord;
  logic [SYNC_MAX_WIDTH-1:0] decodeFull;
  logic                      stepIsMulti;

  sync_chain #(
    .WIDTH  (WORD_SIZE),
    .STAGES (STAGES)
  ) uChain (
    .clk (clk),
    .rst (rst),
    .d   (inWord),
    .q   (outWord)
  );

  assign decodeFull  = gray2bin(SYNC_MAX_WIDTH'(outWord), $unsigned(WORD_SIZE));
  assign stepIsMulti = popcount(SYNC_MAX_WIDTH'(outWord ^ prevWord)) > 1;

  // History, decode and strobe all look at the same outWord/prevWord pair,
  // so outBin and changed line up on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prevWord <= '0;
      outBin   <= '0;
      changed  <= 1'b0;
    end else begin
      prevWord <= outWord;
      outBin   <= decodeFull[WORD_SIZE-1:0];
      changed  <= (outWord != prevWord);
    end
  end

  // Sticky error: a fresh violation beats a simultaneous clear so that no
  // bad step can slip past unreported.
  always_ff @(posedge clk) begin
    if (rst) begin
      multiBitErr <= 1'b0;
    end else if (stepIsMulti) begin
      multiBitErr <= 1'b1;
    end else if (errClear) begin
      multiBitErr <= 1'b0;
    end
  end

endmodule
